// File: rtl/mem_stage.sv
// Memory stage: pass-through for ALU ops, req/ack data-memory access for lw/sw,
// with upstream stall while an access is outstanding and a watchdog abort.
module mem_stage #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    input  logic [31:0]       inIns,
    input  logic              ovfIn,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              valid_out,
    output logic [31:0]       o_out,
    output logic [31:0]       d_out,
    output logic [31:0]       insOut,
    output logic              outOvf,
    output logic              mem_err
);

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;
    localparam int         CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, nextState;
    logic [CW-1:0] count;
    logic [31:0]   capO, capIns;
    logic          capOvf;
    logic          isMem, timeoutHit;
    logic          passThru, accept, complete, abort;

    assign isMem      = (inIns[31:27] == OP_SW) || (inIns[31:27] == OP_LW);
    assign timeoutHit = (TIMEOUT != 0) && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        passThru  = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_in && isMem) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    nextState = S_WAIT;
                end else if (valid_in) begin
                    passThru = 1'b1;
                end
            end
            S_WAIT: begin
                // An ack in the watchdog's final cycle still completes normally.
                if (dmem_ack) begin
                    complete  = 1'b1;
                    nextState = S_IDLE;
                end else if (timeoutHit) begin
                    abort     = 1'b1;
                    nextState = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= '0;
            capO       <= '0;
            capIns     <= '0;
            capOvf     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            valid_out  <= 1'b0;
            o_out      <= '0;
            d_out      <= '0;
            insOut     <= '0;
            outOvf     <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            o_out     <= '0;
            d_out     <= '0;
            insOut    <= '0;
            outOvf    <= 1'b0;
            mem_err   <= 1'b0;
            if (passThru) begin
                valid_out <= 1'b1;
                o_out     <= o_in;
                insOut    <= inIns;
                outOvf    <= ovfIn;
            end
            if (accept) begin
                capO       <= o_in;
                capIns     <= inIns;
                capOvf     <= ovfIn;
                dmem_req   <= 1'b1;
                dmem_we    <= (inIns[31:27] == OP_SW);
                dmem_addr  <= o_in[ADDR_W-1:0];
                dmem_wdata <= b_in;
                count      <= '0;
            end
            if (complete || abort) begin
                dmem_req  <= 1'b0;
                valid_out <= 1'b1;
                o_out     <= capO;
                insOut    <= capIns;
                outOvf    <= capOvf;
                d_out     <= (complete && !dmem_we) ? dmem_rdata : '0;
                mem_err   <= abort;
            end else if (state == S_WAIT && count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, lw/sw handshakes,
// watchdog timeout and reset during an outstanding access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [31:0] o_in, b_in, inIns;
    logic        ovfIn;
    logic        stall;
    logic        dmem_req, dmem_we;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        valid_out;
    logic [31:0] o_out, d_out, insOut;
    logic        outOvf, mem_err;

    int unsigned nCmp = 0;
    int unsigned nBad = 0;

    localparam logic [31:0] INS_ADD = {5'b00000, 27'h0012345};
    localparam logic [31:0] INS_LW  = {5'b01000, 27'h0000ABC};
    localparam logic [31:0] INS_SW  = {5'b00111, 27'h0000DEF};

    mem_stage #(.ADDR_W(12), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .o_in(o_in), .b_in(b_in),
        .inIns(inIns), .ovfIn(ovfIn), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
        .o_out(o_out), .d_out(d_out), .insOut(insOut), .outOvf(outOvf), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic edgeSample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; valid_in = 1'b1; inIns = INS_ADD; o_in = 32'h55; b_in = 32'h66;
        ovfIn = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        edgeSample();
        edgeSample();
        nCmp++; if ({valid_out, o_out, d_out, insOut, outOvf, mem_err} !== '0) begin
            nBad++; $display("FAIL reset_outs: got v=%b o=%h d=%h i=%h ovf=%b err=%b expected all 0",
                             valid_out, o_out, d_out, insOut, outOvf, mem_err); end
        nCmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
            nBad++; $display("FAIL reset_dmem: got req=%b we=%b a=%h wd=%h expected all 0",
                             dmem_req, dmem_we, dmem_addr, dmem_wdata); end
        nCmp++; if (stall !== 1'b0) begin
            nBad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        @(negedge clk);
        reset_n = 1'b1; valid_in = 1'b0;
        edgeSample();
    endtask

    task automatic test_passthru();
        @(negedge clk);
        valid_in = 1'b1; inIns = INS_ADD; o_in = 32'h0000_0005; ovfIn = 1'b1;
        #1;
        nCmp++; if (stall !== 1'b0) begin
            nBad++; $display("FAIL add_stall: got %b expected 0", stall); end
        edgeSample();
        nCmp++; if ({valid_out, o_out, outOvf, d_out, insOut} !== {1'b1, 32'h5, 1'b1, 32'h0, INS_ADD}) begin
            nBad++; $display("FAIL add_out: got v=%b o=%h ovf=%b d=%h i=%h expected v=1 o=5 ovf=1 d=0 i=%h",
                             valid_out, o_out, outOvf, d_out, insOut, INS_ADD); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o_in = 32'h100 + i; ovfIn = 1'b0;
            edgeSample();
            nCmp++; if ({valid_out, o_out, outOvf} !== {1'b1, 32'h100 + i, 1'b0}) begin
                nBad++; $display("FAIL b2b_%0d: got v=%b o=%h ovf=%b expected v=1 o=%h ovf=0",
                                 i, valid_out, o_out, outOvf, 32'h100 + i); end
        end
        @(negedge clk);
        valid_in = 1'b0;
        edgeSample();
        nCmp++; if ({valid_out, insOut, o_out} !== '0) begin
            nBad++; $display("FAIL bubble: got v=%b i=%h o=%h expected 0", valid_out, insOut, o_out); end
    endtask

    task automatic test_lw();
        int unsigned stallCycles = 0;
        @(negedge clk);
        valid_in = 1'b1; inIns = INS_LW; o_in = 32'h0000_00A4; b_in = 32'h9999; ovfIn = 1'b0;
        dmem_ack = 1'b0;
        #1;
        if (stall === 1'b1) stallCycles++;
        edgeSample();
        nCmp++; if (valid_out !== 1'b0) begin
            nBad++; $display("FAIL lw_novalid: got %b expected 0", valid_out); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            dmem_ack = (k == 4); dmem_rdata = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (stall === 1'b1) stallCycles++;
            nCmp++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 12'h0A4}) begin
                nBad++; $display("FAIL lw_req_%0d: got req=%b we=%b a=%h expected req=1 we=0 a=0a4",
                                 k, dmem_req, dmem_we, dmem_addr); end
        end
        edgeSample();
        nCmp++; if (stallCycles != 4) begin
            nBad++; $display("FAIL lw_stall_cycles: got %0d expected 4", stallCycles); end
        nCmp++; if ({valid_out, d_out, o_out, insOut, mem_err, dmem_req} !==
                    {1'b1, 32'hDEAD_BEEF, 32'h0A4, INS_LW, 1'b0, 1'b0}) begin
            nBad++; $display("FAIL lw_done: got v=%b d=%h o=%h i=%h err=%b req=%b expected v=1 d=deadbeef o=a4 err=0 req=0",
                             valid_out, d_out, o_out, insOut, mem_err, dmem_req); end
        @(negedge clk);
        valid_in = 1'b0; dmem_ack = 1'b0;
        edgeSample();
        nCmp++; if (valid_out !== 1'b0) begin
            nBad++; $display("FAIL lw_single: got %b expected 0", valid_out); end
    endtask

    task automatic test_sw();
        @(negedge clk);
        valid_in = 1'b1; inIns = INS_SW; o_in = 32'h0000_0010; b_in = 32'h0000_1234; ovfIn = 1'b1;
        dmem_ack = 1'b0;
        #1;
        nCmp++; if (stall !== 1'b1) begin
            nBad++; $display("FAIL sw_stall0: got %b expected 1", stall); end
        edgeSample();
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        nCmp++; if ({dmem_req, dmem_we, dmem_wdata, dmem_addr, stall} !== {1'b1, 1'b1, 32'h1234, 12'h010, 1'b0}) begin
            nBad++; $display("FAIL sw_req: got req=%b we=%b wd=%h a=%h stall=%b expected 1 1 1234 010 0",
                             dmem_req, dmem_we, dmem_wdata, dmem_addr, stall); end
        edgeSample();
        nCmp++; if ({valid_out, d_out, outOvf, dmem_req, o_out} !== {1'b1, 32'h0, 1'b1, 1'b0, 32'h10}) begin
            nBad++; $display("FAIL sw_done: got v=%b d=%h ovf=%b req=%b o=%h expected 1 0 1 0 10",
                             valid_out, d_out, outOvf, dmem_req, o_out); end
        // ack left high while idle must have no effect on the next add
        @(negedge clk);
        inIns = INS_ADD; o_in = 32'h77; ovfIn = 1'b0;
        #1;
        nCmp++; if (stall !== 1'b0) begin
            nBad++; $display("FAIL sw_next_stall: got %b expected 0", stall); end
        edgeSample();
        nCmp++; if ({valid_out, o_out, d_out, dmem_req} !== {1'b1, 32'h77, 32'h0, 1'b0}) begin
            nBad++; $display("FAIL sw_next: got v=%b o=%h d=%h req=%b expected 1 77 0 0",
                             valid_out, o_out, d_out, dmem_req); end
        @(negedge clk);
        valid_in = 1'b0; dmem_ack = 1'b0;
        edgeSample();
    endtask

    task automatic test_timeout(input logic ackLast);
        int unsigned reqCycles = 0;
        int unsigned earlyValid = 0;
        @(negedge clk);
        valid_in = 1'b1; inIns = INS_LW; o_in = 32'h0FF; ovfIn = 1'b0; dmem_ack = 1'b0;
        edgeSample();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            dmem_ack = ackLast && (k == 16); dmem_rdata = 32'hCAFE_F00D;
            #1;
            if (dmem_req === 1'b1) reqCycles++;
            if (k == 16) begin
                nCmp++; if (stall !== 1'b0) begin
                    nBad++; $display("FAIL to_stall_last: got %b expected 0", stall); end
            end
            edgeSample();
            if (k < 16 && valid_out !== 1'b0) earlyValid++;
        end
        nCmp++; if (reqCycles != 16 || earlyValid != 0) begin
            nBad++; $display("FAIL to_req_cycles: got req=%0d early_valid=%0d expected 16 0",
                             reqCycles, earlyValid); end
        if (ackLast) begin
            nCmp++; if ({valid_out, mem_err, d_out, dmem_req} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
                nBad++; $display("FAIL to_ack_last: got v=%b err=%b d=%h req=%b expected 1 0 cafef00d 0",
                                 valid_out, mem_err, d_out, dmem_req); end
        end else begin
            nCmp++; if ({valid_out, mem_err, d_out, dmem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
                nBad++; $display("FAIL to_abort: got v=%b err=%b d=%h req=%b expected 1 1 0 0",
                                 valid_out, mem_err, d_out, dmem_req); end
        end
        @(negedge clk);
        valid_in = 1'b0; dmem_ack = 1'b0;
        edgeSample();
        nCmp++; if ({valid_out, mem_err} !== 2'b00) begin
            nBad++; $display("FAIL to_pulse: got v=%b err=%b expected 0 0", valid_out, mem_err); end
    endtask

    task automatic test_reset_wait();
        int unsigned lateValid = 0;
        @(negedge clk);
        valid_in = 1'b1; inIns = INS_LW; o_in = 32'h0AB; dmem_ack = 1'b0;
        edgeSample();
        edgeSample();
        @(negedge clk);
        reset_n = 1'b0; valid_in = 1'b0;
        edgeSample();
        nCmp++; if ({dmem_req, valid_out, stall} !== 3'b000) begin
            nBad++; $display("FAIL rst_wait: got req=%b v=%b stall=%b expected 0 0 0",
                             dmem_req, valid_out, stall); end
        @(negedge clk);
        reset_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            edgeSample();
            if (valid_out !== 1'b0 || dmem_req !== 1'b0 || d_out !== 32'h0) lateValid++;
        end
        nCmp++; if (lateValid != 0) begin
            nBad++; $display("FAIL rst_late_ack: got %0d bad cycles expected 0", lateValid); end
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; valid_in = 1'b0; o_in = '0; b_in = '0; inIns = '0; ovfIn = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        test_reset();
        test_passthru();
        test_lw();
        test_sw();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
